// File: rtl/pipeline_merge_arbitrated.sv
// Merges INPUT_COUNT skid-buffered ready/valid streams into one registered
// output stream using fixed-priority or round-robin arbitration, with an
// optional packet lock that holds the grant until the last-flagged word.
module pipeline_merge_arbitrated #(
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned INPUT_COUNT = 4,
    parameter string       ARBITRATION = "PRIORITY",
    parameter int unsigned PACKET_MODE = 0,
    localparam int unsigned TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic [INPUT_COUNT-1:0] input_valid,
    output logic [INPUT_COUNT-1:0] input_ready,
    input  logic [TOTAL_WIDTH-1:0] input_data,
    input  logic [INPUT_COUNT-1:0] input_last,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [WORD_WIDTH-1:0]  output_data,
    output logic                   output_last,
    output logic [INPUT_COUNT-1:0] output_source,
    output logic                   locked
);

    localparam int unsigned PTR_W  = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
    localparam bit          IS_RR  = (ARBITRATION == "ROUND_ROBIN");
    localparam bit          PKT_EN = (PACKET_MODE != 0);

    // Elaboration-time parameter sanity
    if (WORD_WIDTH < 1) begin : g_bad_width
        $error("pipeline_merge_arbitrated: WORD_WIDTH must be >= 1");
    end
    if (INPUT_COUNT < 2) begin : g_bad_count
        $error("pipeline_merge_arbitrated: INPUT_COUNT must be >= 2");
    end
    if (!(ARBITRATION == "PRIORITY" || ARBITRATION == "ROUND_ROBIN")) begin : g_bad_arb
        $error("pipeline_merge_arbitrated: ARBITRATION must be PRIORITY or ROUND_ROBIN");
    end

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    logic [WORD_WIDTH-1:0]  head_data [INPUT_COUNT];
    logic [INPUT_COUNT-1:0] head_last;
    logic [INPUT_COUNT-1:0] head_valid;
    logic [INPUT_COUNT-1:0] cand;
    logic [INPUT_COUNT-1:0] grant;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       lock_idx_q;
    logic [PTR_W-1:0]       lock_idx_d;
    lock_state_t            state_q;
    lock_state_t            state_d;
    logic                   can_load;
    logic                   transfer;
    logic [WORD_WIDTH-1:0]  win_data;
    logic                   win_last;

    assign can_load = ~output_valid | output_ready;
    assign transfer = can_load & (|cand);
    assign win_data = head_data[grant_idx];
    assign win_last = head_last[grant_idx];

    for (genvar i = 0; i < INPUT_COUNT; i++) begin : g_skid
        logic [WORD_WIDTH-1:0] d0;
        logic [WORD_WIDTH-1:0] d1;
        logic                  l0;
        logic                  l1;
        logic [1:0]            cnt;
        logic                  rdy_q;
        logic                  push;
        logic                  pop;

        assign push          = input_valid[i] & rdy_q;
        assign pop           = transfer & grant[i];
        assign head_data[i]  = d0;
        assign head_last[i]  = l0;
        assign head_valid[i] = (cnt != 2'd0);
        assign input_ready[i] = rdy_q;

        // Two-entry skid buffer; entry 0 is the head, ready drops only when full
        always_ff @(posedge clock or negedge clear_n) begin
            if (!clear_n) begin
                d0    <= '0;
                d1    <= '0;
                l0    <= 1'b0;
                l1    <= 1'b0;
                cnt   <= 2'd0;
                rdy_q <= 1'b1;
            end else begin
                case (cnt)
                    2'd0: begin
                        if (push) begin
                            d0  <= input_data[WORD_WIDTH*i +: WORD_WIDTH];
                            l0  <= input_last[i];
                            cnt <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (push && pop) begin
                            d0 <= input_data[WORD_WIDTH*i +: WORD_WIDTH];
                            l0 <= input_last[i];
                        end else if (push) begin
                            d1    <= input_data[WORD_WIDTH*i +: WORD_WIDTH];
                            l1    <= input_last[i];
                            cnt   <= 2'd2;
                            rdy_q <= 1'b0;
                        end else if (pop) begin
                            cnt <= 2'd0;
                        end
                    end
                    default: begin
                        if (pop) begin
                            d0    <= d1;
                            l0    <= l1;
                            cnt   <= 2'd1;
                            rdy_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Candidate set: buffered inputs, restricted to the owner while locked
    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
            cand[i] = head_valid[i] & (~locked | (lock_idx_q == PTR_W'(i)));
        end
    end

    // Grant selection: lowest index, or first found scanning up from rr_ptr+1
    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (IS_RR) begin
            for (int unsigned k = 1; k <= INPUT_COUNT; k++) begin
                idx = 32'(rr_ptr_q) + k;
                if (idx >= INPUT_COUNT) begin
                    idx = idx - INPUT_COUNT;
                end
                if (!found && cand[PTR_W'(idx)]) begin
                    grant[PTR_W'(idx)] = 1'b1;
                    grant_idx          = PTR_W'(idx);
                    found              = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
                if (!found && cand[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = PTR_W'(i);
                    found     = 1'b1;
                end
            end
        end
    end

    // Output register: loads on transfer, empties when drained without refill
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            output_valid  <= 1'b0;
            output_data   <= '0;
            output_last   <= 1'b0;
            output_source <= '0;
        end else if (transfer) begin
            output_valid  <= 1'b1;
            output_data   <= win_data;
            output_last   <= win_last;
            output_source <= grant;
        end else if (output_ready) begin
            output_valid  <= 1'b0;
        end
    end

    // Round-robin pointer follows the last winner (per packet in packet mode)
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            rr_ptr_q <= PTR_W'(INPUT_COUNT - 1);
        end else if (transfer && (!PKT_EN || win_last)) begin
            rr_ptr_q <= grant_idx;
        end
    end

    // Lock state register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= ST_UNLOCKED;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Lock next state: lock on a non-last transfer, release on the owner's last word
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        if (PKT_EN && transfer) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (!win_last) begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = grant_idx;
                    end
                end
                default: begin
                    if (win_last) begin
                        state_d = ST_UNLOCKED;
                    end
                end
            endcase
        end
    end

    // Lock output decode, taken straight from the state register
    always_comb begin
        locked = 1'b0;
        if (state_q == ST_LOCKED) begin
            locked = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_merge_arbitrated.sv
// Self-checking bench: three configurations (priority, round-robin,
// round-robin + packet mode) share one stimulus and are each compared every
// cycle against a queue-based reference model.
module tb_pipeline_merge_arbitrated;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned NC = 3;

    logic           clock = 1'b0;
    logic           clear_n = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_last = '0;
    logic [W*N-1:0] in_data = '0;
    logic           out_ready = 1'b1;

    logic [N-1:0]   in_ready  [NC];
    logic           out_valid [NC];
    logic [W-1:0]   out_data  [NC];
    logic           out_last  [NC];
    logic [N-1:0]   out_src   [NC];
    logic           lk        [NC];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    pipeline_merge_arbitrated #(.WORD_WIDTH(W), .INPUT_COUNT(N),
        .ARBITRATION("PRIORITY"), .PACKET_MODE(0)) u_prio (
        .clock(clock), .clear_n(clear_n), .input_valid(in_valid),
        .input_ready(in_ready[0]), .input_data(in_data), .input_last(in_last),
        .output_valid(out_valid[0]), .output_ready(out_ready),
        .output_data(out_data[0]), .output_last(out_last[0]),
        .output_source(out_src[0]), .locked(lk[0]));

    pipeline_merge_arbitrated #(.WORD_WIDTH(W), .INPUT_COUNT(N),
        .ARBITRATION("ROUND_ROBIN"), .PACKET_MODE(0)) u_rr (
        .clock(clock), .clear_n(clear_n), .input_valid(in_valid),
        .input_ready(in_ready[1]), .input_data(in_data), .input_last(in_last),
        .output_valid(out_valid[1]), .output_ready(out_ready),
        .output_data(out_data[1]), .output_last(out_last[1]),
        .output_source(out_src[1]), .locked(lk[1]));

    pipeline_merge_arbitrated #(.WORD_WIDTH(W), .INPUT_COUNT(N),
        .ARBITRATION("ROUND_ROBIN"), .PACKET_MODE(1)) u_pkt (
        .clock(clock), .clear_n(clear_n), .input_valid(in_valid),
        .input_ready(in_ready[2]), .input_data(in_data), .input_last(in_last),
        .output_valid(out_valid[2]), .output_ready(out_ready),
        .output_data(out_data[2]), .output_last(out_last[2]),
        .output_source(out_src[2]), .locked(lk[2]));

    // Reference model: per-input FIFOs of {last,data} plus output and lock state
    logic [W:0]   mq [NC][N][$];
    bit           m_ov    [NC];
    logic [W-1:0] m_data  [NC];
    bit           m_last  [NC];
    logic [N-1:0] m_src   [NC];
    bit           m_lock  [NC];
    int           m_owner [NC];
    int           m_prev  [NC];

    function automatic bit is_rr(input int c);
        return c != 0;
    endfunction

    function automatic bit is_pm(input int c);
        return c == 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < N; i++) mq[c][i].delete();
            m_ov[c]    = 1'b0;
            m_data[c]  = '0;
            m_last[c]  = 1'b0;
            m_src[c]   = '0;
            m_lock[c]  = 1'b0;
            m_owner[c] = 0;
            m_prev[c]  = N - 1;
        end
    endtask

    // What the configuration should do at the coming rising edge
    task automatic model_step(input int c);
        int         g;
        int         sz [N];
        int         idx;
        bit         can_load;
        logic [W:0] w;
        g = -1;
        can_load = !m_ov[c] || out_ready;
        for (int i = 0; i < N; i++) sz[i] = mq[c][i].size();
        for (int k = 0; k < N; k++) begin
            idx = is_rr(c) ? (m_prev[c] + 1 + k) % N : k;
            if (g < 0 && sz[idx] > 0 && (!m_lock[c] || idx == m_owner[c])) g = idx;
        end
        if (can_load && g >= 0) begin
            w         = mq[c][g].pop_front();
            m_ov[c]   = 1'b1;
            m_data[c] = w[W-1:0];
            m_last[c] = w[W];
            m_src[c]  = N'(1) << g;
            if (is_pm(c)) begin
                if (!m_lock[c] && !w[W]) begin
                    m_lock[c]  = 1'b1;
                    m_owner[c] = g;
                end else if (m_lock[c] && w[W]) begin
                    m_lock[c] = 1'b0;
                end
            end
            if (!is_pm(c) || w[W]) m_prev[c] = g;
        end else if (out_ready) begin
            m_ov[c] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && sz[i] < 2) mq[c][i].push_back({in_last[i], in_data[W*i +: W]});
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] er;
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < N; i++) er[i] = (mq[c][i].size() < 2);
            check($sformatf("c%0d_input_ready", c), 32'(in_ready[c]), 32'(er));
            check($sformatf("c%0d_output_valid", c), 32'(out_valid[c]), 32'(m_ov[c]));
            check($sformatf("c%0d_locked", c), 32'(lk[c]), 32'(m_lock[c]));
            if (m_ov[c]) begin
                check($sformatf("c%0d_output_data", c), 32'(out_data[c]), 32'(m_data[c]));
                check($sformatf("c%0d_output_last", c), 32'(out_last[c]), 32'(m_last[c]));
                check($sformatf("c%0d_output_source", c), 32'(out_src[c]), 32'(m_src[c]));
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy);
        in_valid  = v;
        in_last   = l;
        out_ready = rdy;
        for (int i = 0; i < N; i++) in_data[W*i +: W] = W'($urandom);
        for (int c = 0; c < NC; c++) model_step(c);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic check_reset_values();
        for (int c = 0; c < NC; c++) begin
            check($sformatf("c%0d_rst_output_valid", c), 32'(out_valid[c]), 32'd0);
            check($sformatf("c%0d_rst_input_ready", c), 32'(in_ready[c]), 32'hF);
            check($sformatf("c%0d_rst_locked", c), 32'(lk[c]), 32'd0);
            check($sformatf("c%0d_rst_output_data", c), 32'(out_data[c]), 32'd0);
            check($sformatf("c%0d_rst_output_last", c), 32'(out_last[c]), 32'd0);
            check($sformatf("c%0d_rst_output_source", c), 32'(out_src[c]), 32'd0);
        end
    endtask

    // Reset with all valids high; returns just after a rising edge with clear_n high
    task automatic apply_reset();
        clear_n  = 1'b0;
        in_valid = '1;
        model_reset();
        #1;
        check_reset_values();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values();
        clear_n  = 1'b1;
        in_valid = '0;
    endtask

    localparam logic [N-1:0] PKT_SRC [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
    localparam bit           PKT_LK  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        @(posedge clock);
        #1;
        apply_reset();

        // First-word latency: handshake at edge 1, visible after edge 2
        cycle(4'b0001, 4'b1111, 1'b1);
        check("latency_edge1_valid", 32'(out_valid[0]), 32'd0);
        cycle(4'b0000, 4'b1111, 1'b1);
        check("latency_edge2_valid", 32'(out_valid[0]), 32'd1);
        repeat (2) cycle(4'b0000, 4'b1111, 1'b1);

        // Priority: inputs 1 and 3 streaming, input 1 dominates until it stops
        for (int k = 1; k <= 6; k++) begin
            cycle(4'b1010, 4'b1111, 1'b1);
            if (k >= 2) check("prio_source_held", 32'(out_src[0]), 32'h2);
        end
        repeat (4) cycle(4'b1000, 4'b1111, 1'b1);
        repeat (4) cycle(4'b0000, 4'b1111, 1'b1);

        // Round robin, all valid, single-word packets
        apply_reset();
        for (int k = 1; k <= 12; k++) begin
            cycle(4'b1111, 4'b1111, 1'b1);
            if (k >= 2) begin
                check("rr_source_cycle", 32'(out_src[1]), 32'(1) << ((k - 2) % 4));
                check("rr_pkt_source_cycle", 32'(out_src[2]), 32'(1) << ((k - 2) % 4));
            end
        end
        repeat (4) cycle(4'b0000, 4'b1111, 1'b1);

        // Packet mode: input 2 sends 3 words while input 0 stays valid
        apply_reset();
        cycle(4'b0101, 4'b0001, 1'b1);
        cycle(4'b0101, 4'b0001, 1'b1);
        cycle(4'b0001, 4'b0001, 1'b1);
        check("pkt_source_w1", 32'(out_src[2]), 32'(PKT_SRC[0]));
        check("pkt_locked_w1", 32'(lk[2]), 32'(PKT_LK[0]));
        cycle(4'b0101, 4'b0101, 1'b1);
        check("pkt_source_w2", 32'(out_src[2]), 32'(PKT_SRC[1]));
        check("pkt_locked_w2", 32'(lk[2]), 32'(PKT_LK[1]));
        cycle(4'b0001, 4'b0001, 1'b1);
        check("pkt_source_w3", 32'(out_src[2]), 32'(PKT_SRC[2]));
        check("pkt_locked_w3", 32'(lk[2]), 32'(PKT_LK[2]));
        cycle(4'b0000, 4'b0001, 1'b1);
        check("pkt_source_next", 32'(out_src[2]), 32'(PKT_SRC[3]));
        check("pkt_locked_next", 32'(lk[2]), 32'(PKT_LK[3]));
        repeat (4) cycle(4'b0000, 4'b0001, 1'b1);

        // Backpressure: output stalled for 5 cycles with two active inputs
        apply_reset();
        for (int k = 1; k <= 5; k++) begin
            cycle(4'b0011, 4'b1111, 1'b0);
            if (k >= 3) check("bp_input_ready", 32'(in_ready[0]), 32'hC);
        end
        repeat (6) cycle(4'b0000, 4'b1111, 1'b1);

        // Reset during a locked packet, then a packet from another input
        apply_reset();
        cycle(4'b0010, 4'b0000, 1'b1);
        cycle(4'b0010, 4'b0000, 1'b1);
        check("midpkt_locked_before", 32'(lk[2]), 32'd1);
        #3;
        apply_reset();
        cycle(4'b1000, 4'b0000, 1'b1);
        cycle(4'b1000, 4'b1000, 1'b1);
        check("midpkt_new_source", 32'(out_src[2]), 32'h8);
        repeat (3) cycle(4'b0000, 4'b0000, 1'b1);

        // Randomized traffic against the model
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            cycle(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
